pc_fetch_sequencer: RTL
=======================

// Module: pc_fetch_sequencer
// PURPOSE
//  Sequences the program counter for the single-cycle RV32I core. Drives the
//  instruction-memory request handshake, selects the next PC (sequential, redirect,
//  trap), absorbs memory wait states and stalls, and halts on ECALL/EBREAK or bus timeout.
//  Sits between the decode/branch unit (redirect source) and instruction memory.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset
//  TRAP_VECTOR   32'h0000_0100  PC loaded on misaligned redirect (PC_MISALIGN_TRAP_EN only)
//  MAX_WAIT      15             max consecutive cycles imem_gnt may stay low before bus error
// PORTS
//  clk              in   1   system clock, rising edge
//  rst              in   1   synchronous, active-high reset
//  stall            in   1   core stall; blocks PC advance
//  imem_req         out  1   instruction fetch request
//  imem_addr        out  32  fetch address (== instruct_address)
//  imem_gnt         in   1   imem accepts request this cycle
//  redirect_valid   in   1   taken branch / JAL / JALR
//  redirect_target  in   32  redirect destination
//  halt_req         in   1   ECALL/EBREAK retiring
//  instruct_address out  32  current PC
//  fetch_valid      out  1   handshake completes this cycle (imem_req & imem_gnt & !stall)
//  halted           out  1   sequencer stopped
//  bus_err          out  1   sticky: imem timeout occurred
//  misalign         out  1   1-cycle pulse on misaligned redirect (0 without macro)
// BEHAVIOUR
//  - Reset: instruct_address=RESET_VECTOR, state=BOOT, imem_req=0, halted=0, bus_err=0,
//    misalign=0, pending redirect cleared, wait count=0. Reset mid-wait abandons request.
//  - States: BOOT -> FETCH (one cycle, unconditional). FETCH: imem_req=1.
//    FETCH & !gnt -> WAIT. WAIT: imem_req=1, address held stable, wait count++ per cycle;
//    gnt -> FETCH. WAIT & count==MAX_WAIT & !gnt -> HALTED, bus_err<=1.
//    HALTED: imem_req=0, PC frozen, halted=1; exits only via rst.
//  - Handshake edge (fetch_valid=1): PC updates next edge. Priority: redirect_valid >
//    pending redirect > PC+4. halt_req at handshake -> HALTED, PC unchanged.
//  - Stall with gnt: no handshake, PC and address held, state stays FETCH, wait count not incremented.
//  - redirect_valid without handshake (WAIT or stall): target latched as pending;
//    later redirect overwrites pending; pending cleared when consumed.
//  - PC+4 modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
//  - Wait count clears on every handshake and on entering FETCH.
//  - Latency: redirect presented at handshake edge is the fetch address the next cycle.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: redirect target with [1:0]!=0 loads TRAP_VECTOR
//    instead, misalign=1 for the cycle after the update; pending targets checked on consumption.
//  Undefined: target[1:0] forced to 2'b00, misalign tied 0, TRAP_VECTOR unused.
// STRUCTURE
//  Shared package riscv_core_pkg: fetch state enum (BOOT/FETCH/WAIT/HALTED),
//  XLEN=32, INSTR_BYTES=4, default RESET_VECTOR/TRAP_VECTOR constants.
//  One sub-module: pc_wait_timer (count, clear, expired flag, MAX_WAIT param).
// TESTING
//  1. rst 2 cycles, gnt=1 -> BOOT 1 cycle, then addr 0x0,0x4,0x8 on successive cycles.
//  2. gnt low 3 cycles at PC 0x8 -> addr held 0x8, fetch_valid=0, then 0xC after grant.
//  3. redirect 0x40 while in WAIT, then new redirect 0x80 before gnt -> next PC 0x80.
//  4. gnt low 16 cycles (MAX_WAIT=15) -> bus_err=1, halted=1, imem_req=0 until rst.
//  5. PC=0xFFFF_FFFC, gnt=1 -> next PC 0x0; halt_req at handshake -> PC frozen, halted=1.
//  6. redirect 0x42: macro on -> PC=0x100, misalign pulse; macro off -> PC=0x40, misalign=0.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the RV32I core front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_core_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_wait_timer.sv
// Counts consecutive cycles an instruction fetch goes ungranted.
// Latency: count updates one edge after inc/clr; expired is combinational on the count.
// Backpressure: none; saturates at MAX_WAIT, clr wins over inc.
module pc_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(MAX_WAIT));

    // Wait counter: cleared on handshake / return to FETCH, saturating increment otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC sequencer and imem request handshake for the single-cycle RV32I core.
// Latency: redirect at the handshake edge is the fetch address next cycle.
// Backpressure: imem_gnt low or stall holds the PC; redirects seen meanwhile are kept as pending.
// Optional feature: PC_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VECTOR.
module pc_fetch_sequencer
    import riscv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
    parameter int              MAX_WAIT     = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    output logic [XLEN-1:0] instruct_address,
    output logic            fetch_valid,
    output logic            halted,
    output logic            bus_err,
    output logic            misalign
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_q;
    logic            pend_vld_q;
    logic            bus_err_q;

    logic            handshake;
    logic            advance;
    logic            use_target;
    logic [XLEN-1:0] sel_target;
    logic [XLEN-1:0] target_pc;
    logic            target_bad;
    logic [XLEN-1:0] next_pc;
    logic            timer_clr;
    logic            timer_inc;
    logic            timer_expired;

    assign imem_req         = (state_q == ST_FETCH) || (state_q == ST_WAIT);
    assign handshake        = imem_req && imem_gnt && !stall;
    assign advance          = handshake && !halt_req;
    assign fetch_valid      = handshake;
    assign imem_addr        = pc_q;
    assign instruct_address = pc_q;
    assign halted           = (state_q == ST_HALTED);
    assign bus_err          = bus_err_q;

    // A live redirect beats the one remembered from a blocked cycle
    assign use_target = redirect_valid || pend_vld_q;
    assign sel_target = redirect_valid ? redirect_target : pend_q;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;

    assign target_bad = use_target && (sel_target[1:0] != 2'b00);
    assign target_pc  = target_bad ? TRAP_VECTOR : sel_target;
    assign misalign   = misalign_q;

    // Misalign pulse lines up with the cycle the trap vector is being fetched
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= advance && target_bad;
        end
    end
`else
    logic unused_trap_vector;

    assign unused_trap_vector = ^TRAP_VECTOR;
    assign target_bad         = 1'b0;
    assign target_pc          = sel_target & ~32'h0000_0003;
    assign misalign           = 1'b0;
`endif

    assign next_pc = use_target ? target_pc : (pc_q + 32'(INSTR_BYTES));

    // Timer counts every ungranted request cycle, including the one that leaves FETCH
    assign timer_inc = imem_req && !imem_gnt;
    assign timer_clr = handshake || ((state_q == ST_WAIT) && imem_gnt);

    pc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    // Next-state: boot once, fetch/wait on the grant, halt on halt_req or timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (handshake && halt_req) begin
                    state_d = ST_HALTED;
                end else if (!imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_gnt) begin
                    state_d = (handshake && halt_req) ? ST_HALTED : ST_FETCH;
                end else if (timer_expired) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    // State, PC, pending redirect and sticky bus error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                pc_q <= next_pc;
            end
            if (handshake) begin
                pend_vld_q <= 1'b0;
            end else if (imem_req && redirect_valid) begin
                pend_q     <= redirect_target;
                pend_vld_q <= 1'b1;
            end
            if ((state_q == ST_WAIT) && !imem_gnt && timer_expired) begin
                bus_err_q <= 1'b1;
            end
        end
    end

endmodule
